// File: rtl/neuron_accumulator.sv
// Sums N_INPUTS signed terms into a wide accumulator and emits one saturated DATA_W result.
// Optional macro NEURON_RELU_EN: clamp negative results to zero after saturation.
module neuron_accumulator #(
   parameter int DATA_W   = 32,
   parameter int ACC_W    = 40,
   parameter int N_INPUTS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sat
);

   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

   typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

   state_t                   state, state_nxt;
   logic signed [ACC_W-1:0]  acc, sum;
   logic [CNT_W-1:0]         count;
   logic                     accept, last, out_fire;
   logic [ACC_W-DATA_W:0]    hi;
   logic                     in_range, sat_flag;
   logic [DATA_W-1:0]        sat_data, res_data;

   assign accept   = in_valid && in_ready;
   assign last     = (count == LAST);
   assign out_fire = out_valid && out_ready;
   assign sum      = acc + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

   // Result fits DATA_W iff all bits from the DATA_W sign bit upward agree.
   assign hi       = sum[ACC_W-1:DATA_W-1];
   assign in_range = (&hi) | ~(|hi);

   always_comb begin
      sat_flag = ~in_range;
      sat_data = sum[DATA_W-1:0];
      if (!in_range)
         sat_data = sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`ifdef NEURON_RELU_EN
      res_data = sat_data[DATA_W-1] ? '0 : sat_data;
`else
      res_data = sat_data;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clr)
         state_nxt = ACCUM;
      else begin
         case (state)
            ACCUM:   if (accept && last) state_nxt = OUT;
            OUT:     if (out_ready)      state_nxt = ACCUM;
            default: state_nxt = ACCUM;
         endcase
      end
   end

   always_comb begin
      in_ready = (state == ACCUM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (clr) begin
         // out_data/out_sat deliberately keep their last values
         acc       <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            if (last) begin
               out_data  <= res_data;
               out_sat   <= sat_flag;
               out_valid <= 1'b1;
               acc       <= '0;
               count     <= '0;
            end else begin
               acc   <= sum;
               count <= count + 1'b1;
            end
         end
         if (out_fire) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator (N_INPUTS=4) with a queue scoreboard of expected results.
module tb_neuron_accumulator;

   localparam int DW = 32;
   localparam int N  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_sat;

   int errors = 0;
   int checks = 0;

   logic [DW:0] exp_q[$];   // {sat, data}
   longint      m_acc = 0;
   int          m_cnt = 0;

   neuron_accumulator #(.DATA_W(DW), .ACC_W(40), .N_INPUTS(N)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW:0] model_result(input longint s);
      logic [DW:0] r;
      if (s > 64'sd2147483647)        r = {1'b1, 32'h7FFF_FFFF};
      else if (s < -64'sd2147483648)  r = {1'b1, 32'h8000_0000};
      else                            r = {1'b0, s[31:0]};
`ifdef NEURON_RELU_EN
      if (r[DW-1]) r[DW-1:0] = '0;
`endif
      return r;
   endfunction

   // One clock: drive inputs at the falling edge, check the held outputs, advance the model.
   task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic c);
      logic rdy;
      @(negedge clk);
      in_valid = iv; in_data = id; out_ready = ordy; clr = c;
      rdy = (exp_q.size() == 0);
      chk("out_valid", {31'b0, out_valid}, {31'b0, !rdy});
      chk("in_ready",  {31'b0, in_ready},  {31'b0, rdy});
      if (!rdy) begin
         chk("out_data", out_data, exp_q[0][DW-1:0]);
         chk("out_sat",  {31'b0, out_sat}, {31'b0, exp_q[0][DW]});
      end
      if (c) begin
         exp_q.delete();
         m_acc = 0;
         m_cnt = 0;
      end else begin
         if (!rdy && ordy) void'(exp_q.pop_front());
         if (iv && rdy) begin
            m_acc += longint'($signed(id));
            m_cnt++;
            if (m_cnt == N) begin
               exp_q.push_back(model_result(m_acc));
               m_acc = 0;
               m_cnt = 0;
            end
         end
      end
   endtask

   task automatic term(input logic [DW-1:0] id, input logic ordy);
      step(1'b1, id, ordy, 1'b0);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, '0, ordy, 1'b0);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data",  out_data, 32'd0);
      chk("rst_out_sat",   {31'b0, out_sat}, 32'd0);
      chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;

      // back-to-back, consumer always ready: 33
      term(32'd8, 1'b1); term(32'd20, 1'b1); term(32'd4, 1'b1); term(32'd1, 1'b1);
      idle(1'b1); idle(1'b1);

      // gaps, then stalled output while 99 is offered
      term(32'd1, 1'b0); idle(1'b0); term(32'd2, 1'b0); idle(1'b0);
      term(32'd3, 1'b0); term(32'd4, 1'b0);
      repeat (5) term(32'd99, 1'b0);
      term(32'd99, 1'b1);
      term(32'd10, 1'b1); term(32'd10, 1'b1); term(32'd10, 1'b1); term(32'd10, 1'b1);
      idle(1'b1); idle(1'b1);

      // positive and negative saturation
      repeat (4) term(32'h7FFF_FFFF, 1'b1);
      idle(1'b1); idle(1'b1);
      repeat (4) term(32'h8000_0000, 1'b1);
      idle(1'b1); idle(1'b1);

      // small negative result
      term(-32'sd10, 1'b1); term(32'd3, 1'b1); term(32'd2, 1'b1); term(32'd1, 1'b1);
      idle(1'b1); idle(1'b1);

      // pseudo-random terms
      for (int i = 0; i < 8; i++) term($urandom, 1'b1);
      idle(1'b1); idle(1'b1);

      // clr with a simultaneous term discards the partial sum
      term(32'd5, 1'b1); term(32'd5, 1'b1);
      step(1'b1, 32'd5, 1'b1, 1'b1);
      repeat (4) term(32'd1, 1'b0);
      idle(1'b0); idle(1'b0);

      // async reset while a result is pending
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("async_rst_out_data",  out_data, 32'd0);
      exp_q.delete();
      m_acc = 0;
      m_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1);
      term(32'd2, 1'b1); term(32'd2, 1'b1); term(32'd2, 1'b1); term(32'd2, 1'b1);
      idle(1'b1); idle(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
